// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller: state encoding
// and the lamp bundle driven by the output decode.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        PED_WALK  = 3'd6,
        FLASH     = 3'd7
    } state_t;

    typedef struct packed {
        logic ns_g;
        logic ns_y;
        logic ns_r;
        logic ew_g;
        logic ew_y;
        logic ew_r;
        logic walk;
    } lamps_t;

endpackage

// File: rtl/traffic_ctrl_phase_timer.sv
// Tick counter for the timed phases; expire marks the last tick
// of the selected duration and the counter wraps to zero there.
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clear,
    input  logic [CNT_W:0]   dur,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   dur_m1;

    assign dur_m1 = dur - (CNT_W+1)'(1);
    assign expire = tick && (cnt == dur_m1[CNT_W-1:0]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= expire ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_ctrl.sv
// Four-way intersection controller: NS/EW phases with all-red
// clearance, latched pedestrian walk phase and night flashing.
module traffic_ctrl
    import traffic_pkg::*;
#(
    parameter int NS_G_TIME   = 5,
    parameter int NS_Y_TIME   = 2,
    parameter int EW_G_TIME   = 5,
    parameter int EW_Y_TIME   = 2,
    parameter int ALLRED_TIME = 1,
    parameter int PED_TIME    = 4,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       flash_en,
    output logic       ns_g,
    output logic       ns_y,
    output logic       ns_r,
    output logic       ew_g,
    output logic       ew_y,
    output logic       ew_r,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] state_o
);

    localparam int MAX_DUR = 2 ** CNT_W;

    if (NS_G_TIME > MAX_DUR || NS_Y_TIME > MAX_DUR ||
        EW_G_TIME > MAX_DUR || EW_Y_TIME > MAX_DUR ||
        ALLRED_TIME > MAX_DUR || PED_TIME > MAX_DUR) begin : g_dur_chk
        $error("traffic_ctrl: a duration exceeds the CNT_W range");
    end

    state_t         state;
    state_t         nxt;
    logic           expire;
    logic           blink;
    logic [CNT_W:0] dur;
    lamps_t         lamps;

    always_comb begin
        dur = (CNT_W+1)'(1);
        unique case (state)
            NS_GREEN:  dur = (CNT_W+1)'(NS_G_TIME);
            NS_YELLOW: dur = (CNT_W+1)'(NS_Y_TIME);
            ALLRED_A:  dur = (CNT_W+1)'(ALLRED_TIME);
            EW_GREEN:  dur = (CNT_W+1)'(EW_G_TIME);
            EW_YELLOW: dur = (CNT_W+1)'(EW_Y_TIME);
            ALLRED_B:  dur = (CNT_W+1)'(ALLRED_TIME);
            PED_WALK:  dur = (CNT_W+1)'(PED_TIME);
            FLASH:     dur = (CNT_W+1)'(1);
        endcase
    end

    // Held clear through FLASH so ALLRED_B starts from zero on exit.
    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .clear  (state == FLASH),
        .dur    (dur),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= NS_GREEN;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            NS_GREEN:  if (expire) nxt = NS_YELLOW;
            NS_YELLOW: if (expire) nxt = ALLRED_A;
            ALLRED_A:  if (expire) nxt = flash_en ? FLASH : EW_GREEN;
            EW_GREEN:  if (expire) nxt = EW_YELLOW;
            EW_YELLOW: if (expire) nxt = ALLRED_B;
            ALLRED_B: begin
                if (expire) begin
                    if (flash_en)         nxt = FLASH;
                    else if (ped_pending) nxt = PED_WALK;
                    else                  nxt = NS_GREEN;
                end
            end
            PED_WALK:  if (expire) nxt = NS_GREEN;
            FLASH:     if (tick && !flash_en) nxt = ALLRED_B;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ped_pending <= 1'b0;
        end else if (nxt == PED_WALK) begin
            ped_pending <= 1'b0;
        end else if (ped_req && state != PED_WALK) begin
            ped_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            blink <= 1'b0;
        end else if (state == FLASH && tick) begin
            blink <= ~blink;
        end
    end

    always_comb begin
        lamps = '0;
        unique case (state)
            NS_GREEN:  begin lamps.ns_g = 1'b1; lamps.ew_r = 1'b1; end
            NS_YELLOW: begin lamps.ns_y = 1'b1; lamps.ew_r = 1'b1; end
            ALLRED_A:  begin lamps.ns_r = 1'b1; lamps.ew_r = 1'b1; end
            EW_GREEN:  begin lamps.ew_g = 1'b1; lamps.ns_r = 1'b1; end
            EW_YELLOW: begin lamps.ew_y = 1'b1; lamps.ns_r = 1'b1; end
            ALLRED_B:  begin lamps.ns_r = 1'b1; lamps.ew_r = 1'b1; end
            PED_WALK: begin
                lamps.ns_r = 1'b1;
                lamps.ew_r = 1'b1;
                lamps.walk = 1'b1;
            end
            FLASH:     begin lamps.ns_y = blink; lamps.ew_r = blink; end
        endcase
    end

    assign ns_g    = lamps.ns_g;
    assign ns_y    = lamps.ns_y;
    assign ns_r    = lamps.ns_r;
    assign ew_g    = lamps.ew_g;
    assign ew_y    = lamps.ew_y;
    assign ew_r    = lamps.ew_r;
    assign walk    = lamps.walk;
    assign state_o = state;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Bench for traffic_ctrl: directed vector table, dwell sequence and
// randomized run against a phase/elapsed-tick reference model.
module tb_traffic_ctrl;

    localparam logic [6:0] L_NSG = 7'b1000010;
    localparam logic [6:0] L_NSY = 7'b0100010;
    localparam logic [6:0] L_AR  = 7'b0010010;
    localparam logic [6:0] L_EWG = 7'b0011000;
    localparam logic [6:0] L_EWY = 7'b0010100;
    localparam logic [6:0] L_PW  = 7'b0010011;
    localparam logic [6:0] L_OFF = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic       flash_en = 1'b0;
    logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk;
    logic       ped_pending;
    logic [2:0] state_o;
    logic [6:0] dut_l;

    int total = 0;
    int bad = 0;

    traffic_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .ped_req     (ped_req),
        .flash_en    (flash_en),
        .ns_g        (ns_g),
        .ns_y        (ns_y),
        .ns_r        (ns_r),
        .ew_g        (ew_g),
        .ew_y        (ew_y),
        .ew_r        (ew_r),
        .walk        (walk),
        .ped_pending (ped_pending),
        .state_o     (state_o)
    );

    assign dut_l = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk};

    always #5 clk = ~clk;

    // Reference model: phase number, ticks elapsed in phase.
    int dur [8] = '{5, 2, 1, 5, 2, 1, 4, 1};
    int m_ph = 0;
    int m_el = 0;
    bit m_pend = 0;
    bit m_blink = 0;

    function automatic int succ(int ph);
        case (ph)
            0: return 1;
            1: return 2;
            2: return flash_en ? 7 : 3;
            3: return 4;
            4: return 5;
            5: return flash_en ? 7 : (m_pend ? 6 : 0);
            default: return 0;
        endcase
    endfunction

    function automatic logic [6:0] m_lamps();
        case (m_ph)
            0: return L_NSG;
            1: return L_NSY;
            2: return L_AR;
            3: return L_EWG;
            4: return L_EWY;
            5: return L_AR;
            6: return L_PW;
            default: return m_blink ? L_NSY : L_OFF;
        endcase
    endfunction

    task automatic m_step();
        int nx;
        bit np;
        if (!rst) begin
            m_ph = 0; m_el = 0; m_pend = 0; m_blink = 0;
            return;
        end
        nx = m_ph;
        np = m_pend | (ped_req && m_ph != 6);
        if (tick) begin
            if (m_ph == 7) begin
                m_blink = !m_blink;
                if (!flash_en) begin
                    nx = 5;
                    m_el = 0;
                end
            end else if (m_el + 1 >= dur[m_ph]) begin
                m_el = 0;
                nx = succ(m_ph);
            end else begin
                m_el++;
            end
        end
        if (nx == 6 && m_ph != 6) np = 0;
        m_ph = nx;
        m_pend = np;
    endtask

    task automatic cyc();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         n;
        bit         r;
        bit         t;
        bit         p;
        bit         f;
        int         st;
        bit         pend;
        logic [6:0] lamps;
    } vec_t;

    vec_t vt[$];

    task automatic add(int n, bit r, bit t, bit p, bit f,
                       int st, bit pend, logic [6:0] l);
        vec_t v;
        v.n = n; v.r = r; v.t = t; v.p = p; v.f = f;
        v.st = st; v.pend = pend; v.lamps = l;
        vt.push_back(v);
    endtask

    int exp_seq [16] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 3, 4, 4, 5, 0};

    initial begin
        // n  r  t  p  f   st pend lamps
        add(1, 0, 0, 0, 0, 0, 0, L_NSG);
        add(1, 1, 0, 0, 0, 0, 0, L_NSG);
        add(4, 1, 1, 0, 0, 0, 0, L_NSG);
        add(1, 1, 1, 0, 0, 1, 0, L_NSY);
        add(2, 1, 1, 0, 0, 2, 0, L_AR);
        add(1, 1, 1, 0, 0, 3, 0, L_EWG);
        add(1, 1, 0, 1, 0, 3, 1, L_EWG);
        add(4, 1, 1, 0, 0, 3, 1, L_EWG);
        add(1, 1, 1, 0, 0, 4, 1, L_EWY);
        add(2, 1, 1, 0, 0, 5, 1, L_AR);
        add(1, 1, 1, 0, 0, 6, 0, L_PW);
        add(3, 1, 1, 1, 0, 6, 0, L_PW);
        add(1, 1, 1, 0, 0, 0, 0, L_NSG);
        add(1, 1, 0, 1, 0, 0, 1, L_NSG);
        add(5, 1, 1, 0, 1, 1, 1, L_NSY);
        add(3, 1, 1, 0, 1, 7, 1, L_OFF);
        add(1, 1, 1, 0, 1, 7, 1, L_NSY);
        add(1, 1, 0, 0, 0, 7, 1, L_NSY);
        add(1, 1, 1, 0, 0, 5, 1, L_AR);
        add(1, 1, 1, 0, 0, 6, 0, L_PW);
        add(3, 1, 1, 0, 0, 6, 0, L_PW);
        add(1, 1, 1, 0, 0, 0, 0, L_NSG);
        add(5, 1, 1, 0, 0, 1, 0, L_NSY);
        add(2, 1, 1, 0, 0, 2, 0, L_AR);
        add(1, 1, 1, 0, 0, 3, 0, L_EWG);
        add(5, 1, 1, 0, 0, 4, 0, L_EWY);
        add(1, 0, 1, 1, 0, 0, 0, L_NSG);
        add(4, 1, 1, 0, 0, 0, 0, L_NSG);
        add(1, 1, 1, 0, 0, 1, 0, L_NSY);
        add(2, 1, 1, 0, 0, 2, 0, L_AR);
        add(1, 1, 1, 0, 0, 3, 0, L_EWG);
        add(1, 1, 0, 1, 0, 3, 1, L_EWG);
        add(5, 1, 1, 0, 0, 4, 1, L_EWY);
        add(2, 1, 1, 0, 0, 5, 1, L_AR);
        add(1, 1, 1, 0, 1, 7, 1, L_OFF);
        add(1, 1, 1, 0, 0, 5, 1, L_AR);
        add(1, 1, 1, 0, 0, 6, 0, L_PW);

        cyc();
        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].r;
            tick = vt[i].t;
            ped_req = vt[i].p;
            flash_en = vt[i].f;
            repeat (vt[i].n) cyc();
            chk($sformatf("vec%0d_state", i), int'(state_o), vt[i].st);
            chk($sformatf("vec%0d_pend", i), int'(ped_pending), int'(vt[i].pend));
            chk($sformatf("vec%0d_lamps", i), int'(dut_l), int'(vt[i].lamps));
        end

        // Default cycle with tick every 10 clk.
        rst = 1'b0; tick = 1'b0; ped_req = 1'b0; flash_en = 1'b0;
        cyc();
        rst = 1'b1;
        for (int t = 0; t < 16; t++) begin
            tick = 1'b0;
            repeat (9) cyc();
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            chk($sformatf("dwell%0d_state", t), int'(state_o), exp_seq[t]);
            chk($sformatf("dwell%0d_onelamp", t),
                int'($countones({ns_g, ns_y, ns_r}) == 1 &&
                     $countones({ew_g, ew_y, ew_r}) == 1), 1);
        end

        // Randomized run against the model.
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            tick = ($urandom_range(3) == 0);
            ped_req = ($urandom_range(29) == 0);
            if ($urandom_range(149) == 0) flash_en = ~flash_en;
            rst = ($urandom_range(599) != 0);
            cyc();
            chk("rnd_state", int'(state_o), m_ph);
            chk("rnd_pend", int'(ped_pending), int'(m_pend));
            chk("rnd_lamps", int'(dut_l), int'(m_lamps()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
